// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and widths for the UART TX arbiter slice.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker returning the first set request
// at or after ptr (wrapping modulo N_REQ) as a one-hot grant plus its index.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(N_REQ);

    int               slot;
    logic [IDX_W-1:0] slot_idx;

    // Scan from the furthest candidate back to ptr so the nearest request wins;
    // the wrap is an explicit subtract so non-power-of-2 N_REQ works.
    always_comb begin
        grant    = '0;
        idx      = '0;
        slot     = 0;
        slot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            slot = int'(ptr) + i;
            if (slot >= N_REQ) begin
                slot = slot - N_REQ;
            end
            slot_idx = IDX_W'(slot);
            if (req[slot_idx]) begin
                grant           = '0;
                grant[slot_idx] = 1'b1;
                idx             = slot_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular arbiter feeding the UART TX system inputs.
// Optional stall timeout is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_valid,
    input  logic [N_REQ*DATA_W-1:0]  i_data,
    input  logic [N_REQ-1:0]         i_last,
    output logic [N_REQ-1:0]         o_ready,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_valid_tx,
    output logic [DATA_W-1:0]        o_tx_sys_data,
    input  logic                     i_tx_full,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_abort,
    output logic [$clog2(N_REQ)-1:0] o_abort_id
);

    localparam int IDX_W = $clog2(N_REQ);

    uart_arb_state_t  state;
    logic [IDX_W-1:0] gid;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_grant;
    logic [DATA_W-1:0] gid_data;
    logic             handshake;
    logic             msg_end;
    logic             timeout_hit;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (i_req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // The ~o_valid_tx gate absorbs the one-cycle lag of the UART full flag.
    always_comb begin
        o_ready = '0;
        if (state == XFER) begin
            o_ready[gid] = ~i_tx_full & ~o_valid_tx;
        end
    end

    assign gid_data  = i_data[int'(gid)*DATA_W +: DATA_W];
    assign handshake = o_ready[gid] & i_valid[gid];
    assign msg_end   = (handshake & i_last[gid]) | timeout_hit;
    assign next_ptr  = (gid == IDX_W'(N_REQ - 1)) ? '0 : gid + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            o_grant       <= '0;
            gid           <= '0;
            ptr           <= '0;
            o_busy        <= 1'b0;
            o_valid_tx    <= 1'b0;
            o_tx_sys_data <= '0;
            o_done        <= 1'b0;
        end else begin
            o_valid_tx <= handshake;
            o_done     <= 1'b0;
            if (handshake) begin
                o_tx_sys_data <= gid_data;
            end
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        o_grant <= pick_grant;
                        gid     <= pick_idx;
                        o_busy  <= 1'b1;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (msg_end) begin
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             abort_q;
    logic [IDX_W-1:0] abort_id_q;

    // Only cycles where the UART could accept but the requester sends nothing count as stall.
    assign timeout_hit = (state == XFER) & ~handshake & ~i_tx_full &
                         (stall_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            abort_q    <= 1'b0;
            abort_id_q <= '0;
        end else begin
            abort_q    <= timeout_hit;
            abort_id_q <= timeout_hit ? gid : '0;
            if (state != XFER || handshake) begin
                stall_cnt <= '0;
            end else if (!i_tx_full && !timeout_hit) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign o_abort    = abort_q;
    assign o_abort_id = abort_id_q;
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
    assign o_abort            = 1'b0;
    assign o_abort_id         = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized bench for uart_tx_arbiter, checked every
// cycle against a transaction-level reference model kept in the bench.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    typedef logic [8:0] qent_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   i_req;
    logic [N-1:0]   i_valid;
    logic [N*W-1:0] i_data;
    logic [N-1:0]   i_last;
    logic [N-1:0]   o_ready;
    logic [N-1:0]   o_grant;
    logic           o_valid_tx;
    logic [W-1:0]   o_tx_sys_data;
    logic           i_tx_full;
    logic           o_busy;
    logic           o_done;
    logic           o_abort;
    logic [1:0]     o_abort_id;

    int checks   = 0;
    int failures = 0;
    int cycleNo  = 0;

    // Stimulus knobs and per-requester message queues ({last, data}).
    int     validPct   = 100;
    int     fullPct    = 0;
    int     reqDropPct = 0;
    bit     forceFull  = 0;
    bit     rstReq     = 1;
    bit     noValid [N];
    qent_t  msgQ [N][$];
    int     pos [N];

    // Reference model state.
    bit         mKnown  = 0;
    int         mOwner  = -1;
    int         mLast   = 0;
    int         mPtr    = 0;
    int         mStall  = 0;
    int         mAbortId = 0;
    bit         mStrobe = 0;
    bit         mDone   = 0;
    bit         mAbort  = 0;
    logic [7:0] mData   = 8'h00;

    // Logs of what the DUT produced, used by the literal checks.
    int strobeLog[$];
    int strobeCyc[$];
    int grantLog[$];
    int abortLog[$];
    int doneCnt = 0;
    logic [N-1:0] prevGrant = '0;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .i_last        (i_last),
        .o_ready       (o_ready),
        .o_grant       (o_grant),
        .o_valid_tx    (o_valid_tx),
        .o_tx_sys_data (o_tx_sys_data),
        .i_tx_full     (i_tx_full),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_abort       (o_abort),
        .o_abort_id    (o_abort_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    task automatic checkSeq(input string name, input int got[$], input int exp[$]);
        checkEq({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checkEq($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
    endtask

    task automatic pushMsg(input int r, input int bytes[$]);
        for (int i = 0; i < bytes.size(); i++) begin
            msgQ[r].push_back({(i == bytes.size() - 1) ? 1'b1 : 1'b0, bytes[i][7:0]});
        end
    endtask

    task automatic clearLogs();
        strobeLog.delete();
        strobeCyc.delete();
        grantLog.delete();
        abortLog.delete();
        doneCnt = 0;
    endtask

    function automatic bit allIdle();
        bit e;
        e = 1'b1;
        for (int r = 0; r < N; r++) begin
            if (msgQ[r].size() != 0) e = 1'b0;
        end
        return e && (mOwner < 0) && !mDone && !mStrobe;
    endfunction

    // Drive one cycle of inputs from the message queues and knobs.
    task automatic applyStimulus();
        rst = rstReq;
        for (int r = 0; r < N; r++) begin
            if (msgQ[r].size() > 0) begin
                i_req[r]          = ($urandom_range(0, 99) >= reqDropPct);
                i_valid[r]        = !noValid[r] && ($urandom_range(0, 99) < validPct);
                i_data[r*W +: W]  = msgQ[r][pos[r]][7:0];
                i_last[r]         = msgQ[r][pos[r]][8];
            end else begin
                i_req[r]          = 1'b0;
                i_valid[r]        = 1'($urandom_range(0, 1));
                i_data[r*W +: W]  = 8'($urandom);
                i_last[r]         = 1'($urandom_range(0, 1));
            end
        end
        i_tx_full = forceFull || ($urandom_range(0, 99) < fullPct);
    endtask

    // Advance each requester's queue on the bytes it saw accepted; reset restarts messages.
    task automatic collectAccepts();
        for (int r = 0; r < N; r++) begin
            if (rst) begin
                pos[r] = 0;
            end else if (msgQ[r].size() > 0 && i_valid[r] && o_ready[r]) begin
                if (msgQ[r][pos[r]][8]) begin
                    for (int k = 0; k <= pos[r]; k++) void'(msgQ[r].pop_front());
                    pos[r] = 0;
                end else begin
                    pos[r]++;
                end
            end
        end
    endtask

    task automatic runCycle();
        @(posedge clk);
        #1;
        applyStimulus();
        @(negedge clk);
        #1;
        collectAccepts();
    endtask

    // Compare DUT outputs with the model, log observations, then step the model.
    task automatic checkOutput();
        logic [N-1:0] eGrant;
        logic [N-1:0] eReady;
        eGrant = '0;
        eReady = '0;
        if (mOwner >= 0) begin
            eGrant[mOwner] = 1'b1;
            eReady[mOwner] = !i_tx_full && !mStrobe;
        end
        cycleNo++;
        if (mKnown) begin
            checkEq("grant", o_grant, eGrant);
            checkEq("busy", o_busy, (mOwner >= 0) ? 1 : 0);
            checkEq("ready", o_ready, eReady);
            checkEq("valid_tx", o_valid_tx, mStrobe);
            if (mStrobe) checkEq("tx_data", o_tx_sys_data, mData);
            checkEq("done", o_done, mDone);
            checkEq("abort", o_abort, mAbort);
            checkEq("abort_id", o_abort_id, mAbortId);
        end
        if (o_valid_tx === 1'b1) begin
            strobeLog.push_back(int'(o_tx_sys_data));
            strobeCyc.push_back(cycleNo);
        end
        if (o_grant != '0 && prevGrant == '0) begin
            for (int r = 0; r < N; r++) if (o_grant[r]) grantLog.push_back(r);
        end
        prevGrant = o_grant;
        if (o_done === 1'b1) doneCnt++;
        if (o_abort === 1'b1) abortLog.push_back(int'(o_abort_id));

        if (rst) begin
            mKnown = 1; mOwner = -1; mPtr = 0; mStrobe = 0; mDone = 0;
            mAbort = 0; mAbortId = 0; mStall = 0;
        end else if (mKnown) begin
            bit hs;
            bit fin;
            bit tmo;
            hs  = (mOwner >= 0) && eReady[mOwner] && i_valid[mOwner];
            fin = 1'b0;
            tmo = 1'b0;
            if (mDone) begin
                mPtr = (mLast + 1) % N;
            end else if (mOwner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (i_req[(mPtr + k) % N]) begin
                        mOwner = (mPtr + k) % N;
                        mStall = 0;
                        break;
                    end
                end
            end else begin
`ifdef UART_ARB_TIMEOUT_EN
                if (hs) mStall = 0;
                else if (!i_tx_full) begin
                    if (mStall == TO - 1) tmo = 1'b1;
                    else mStall++;
                end
`endif
                fin = (hs && i_last[mOwner]) || tmo;
            end
            if (hs) mData = i_data[mOwner*W +: W];
            mAbort   = tmo;
            mAbortId = tmo ? mOwner : 0;
            mStrobe  = hs;
            mDone    = fin;
            if (fin) begin
                mLast  = mOwner;
                mOwner = -1;
            end
        end
    endtask

    always @(negedge clk) checkOutput();

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (!allIdle() && n < budget) begin
            runCycle();
            n++;
        end
        checkEq(name, allIdle(), 1);
    endtask

    task automatic waitStrobes(input string name, input int count, input int budget);
        int n;
        n = 0;
        while (strobeLog.size() < count && n < budget) begin
            runCycle();
            n++;
        end
        checkEq(name, (strobeLog.size() >= count) ? 1 : 0, 1);
    endtask

    task automatic doReset(input int cycles);
        rstReq = 1;
        repeat (cycles) runCycle();
        rstReq = 0;
    endtask

    initial begin
        int total;
        int len;
        int r;
        int bytes[$];
        rst = 1'b1; i_req = '0; i_valid = '0; i_data = '0; i_last = '0; i_tx_full = 1'b0;
        for (int k = 0; k < N; k++) begin noValid[k] = 0; pos[k] = 0; end

        // Reset state
        doReset(3);
        checkEq("A_grant", o_grant, 0);
        checkEq("A_busy", o_busy, 0);
        checkEq("A_valid", o_valid_tx, 0);
        checkEq("A_done", o_done, 0);

        // Requester 1: three-byte message
        clearLogs();
        bytes = '{32'hA1, 32'hA2, 32'hA3};
        pushMsg(1, bytes);
        waitDrain("B_drain", 200);
        checkSeq("B_data", strobeLog, bytes);
        bytes = '{1};
        checkSeq("B_grants", grantLog, bytes);
        checkEq("B_done_cnt", doneCnt, 1);
        if (strobeCyc.size() == 3) begin
            checkEq("B_gap01", strobeCyc[1] - strobeCyc[0], 2);
            checkEq("B_gap12", strobeCyc[2] - strobeCyc[1], 2);
        end
        runCycle();
        checkEq("B_grant_end", o_grant, 0);

        // Requesters 0 and 2 alternate two-byte messages
        doReset(2);
        clearLogs();
        bytes = '{32'h10, 32'h11}; pushMsg(0, bytes);
        bytes = '{32'h12, 32'h13}; pushMsg(0, bytes);
        bytes = '{32'h20, 32'h21}; pushMsg(2, bytes);
        bytes = '{32'h22, 32'h23}; pushMsg(2, bytes);
        waitDrain("C_drain", 400);
        bytes = '{0, 2, 0, 2};
        checkSeq("C_grants", grantLog, bytes);
        bytes = '{32'h10, 32'h11, 32'h20, 32'h21, 32'h12, 32'h13, 32'h22, 32'h23};
        checkSeq("C_data", strobeLog, bytes);
        checkEq("C_done_cnt", doneCnt, 4);

        // UART full for 20 cycles mid-message
        clearLogs();
        bytes = '{32'h31, 32'h32, 32'h33, 32'h34};
        pushMsg(1, bytes);
        waitStrobes("D_pre", 2, 200);
        forceFull = 1;
        repeat (20) runCycle();
        checkEq("D_strobes_while_full", strobeLog.size(), 2);
        forceFull = 0;
        waitDrain("D_drain", 200);
        checkSeq("D_data", strobeLog, bytes);

        // Reset after byte 2 of a 4-byte message, with a single-byte message pending
        clearLogs();
        bytes = '{32'h41, 32'h42, 32'h43, 32'h44}; pushMsg(2, bytes);
        bytes = '{32'h55}; pushMsg(3, bytes);
        waitStrobes("E_pre", 2, 200);
        rstReq = 1;
        runCycle();
        rstReq = 0;
        runCycle();
        checkEq("E_grant_after_rst", o_grant, 0);
        checkEq("E_busy_after_rst", o_busy, 0);
        checkEq("E_valid_after_rst", o_valid_tx, 0);
        checkEq("E_done_after_rst", o_done, 0);
        clearLogs();
        waitDrain("E_drain", 300);
        bytes = '{32'h41, 32'h42, 32'h43, 32'h44, 32'h55};
        checkSeq("E_data", strobeLog, bytes);
        bytes = '{2, 3};
        checkSeq("E_grants", grantLog, bytes);
        checkEq("E_done_cnt", doneCnt, 2);

        // Randomized traffic
        clearLogs();
        validPct = 60; fullPct = 20; reqDropPct = 10;
        total = 0;
        for (int m = 0; m < 60; m++) begin
            r   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            bytes.delete();
            for (int b = 0; b < len; b++) bytes.push_back($urandom_range(0, 255));
            pushMsg(r, bytes);
            total += len;
        end
        waitDrain("F_drain", 20000);
        checkEq("F_byte_count", strobeLog.size(), total);
        validPct = 100; fullPct = 0; reqDropPct = 0;

`ifdef UART_ARB_TIMEOUT_EN
        // Requester 3 granted but silent: abort, then grant passes to 0
        doReset(2);
        clearLogs();
        bytes = '{32'h66}; pushMsg(2, bytes);
        waitDrain("G_pre", 100);
        noValid[3] = 1;
        bytes = '{32'h77}; pushMsg(3, bytes);
        bytes = '{32'h88}; pushMsg(0, bytes);
        begin
            int n;
            n = 0;
            while (abortLog.size() == 0 && n < 200) begin runCycle(); n++; end
        end
        checkEq("G_abort_cnt", abortLog.size(), 1);
        if (abortLog.size() > 0) checkEq("G_abort_id", abortLog[0], 3);
        msgQ[3].delete();
        pos[3] = 0;
        noValid[3] = 0;
        waitDrain("G_drain", 200);
        bytes = '{2, 3, 0};
        checkSeq("G_grants", grantLog, bytes);
        bytes = '{32'h66, 32'h88};
        checkSeq("G_data", strobeLog, bytes);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, message-granular arbiter sharing the UART transmit system interface between `N_REQ` on-chip requesters. Each requester sends a multi-byte message via valid/ready with a `last` marker. The arbiter locks the grant for the whole message and drives the UART's TX-side system inputs (`i_valid_tx`, `i_tx_sys_data`). It throttles on the UART's `o_tx_full`. It sits between the system logic and the UART module in normal (non-loopback) mode.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be ≥ 2.
- `DATA_W`, 8: byte width; must match the UART system data width.
- `TIMEOUT_CYC`, 1024: stall limit in clock cycles. Used only when `UART_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `i_req`  in  N_REQ: per-requester "message pending".
- `i_valid`  in  N_REQ: per-requester byte valid.
- `i_data`  in  N_REQ×DATA_W: packed per-requester bytes.
- `i_last`  in  N_REQ: marks the final byte of a message.
- `o_ready`  out  N_REQ: byte accepted on cycles where `i_valid[g] & o_ready[g]`.
- `o_grant`  out  N_REQ: one-hot grant, or all zero.
- `o_valid_tx`  out  1: to UART `i_valid_tx`; a one-cycle write strobe.
- `o_tx_sys_data`  out  DATA_W: to UART `i_tx_sys_data`.
- `i_tx_full`  in  1: from UART `o_tx_full`.
- `o_busy`  out  1: high while a grant is held.
- `o_done`  out  1: one-cycle pulse at message end, whether normal or aborted.
- `o_abort`  out  1: one-cycle timeout pulse.
- `o_abort_id`  out  $clog2(N_REQ): index of the aborted requester.

## Operation
- States: IDLE, XFER, DONE.
- **IDLE:** if `i_req` ≠ 0, pick the first set bit at or after `ptr`, wrapping modulo `N_REQ`. Register the one-hot grant and `gid`, then go to XFER.
- **XFER, readiness:** `o_ready[gid] = ~i_tx_full & ~o_valid_tx`. All other `o_ready` bits are 0.
- **XFER, byte handshake:** on a handshake, register `i_data[gid]` into `o_tx_sys_data` and set `o_valid_tx` for the next cycle only.
- **XFER, end of message:** a handshake with `i_last[gid]` moves the FSM to DONE.
- **DONE:** lasts one cycle. `o_grant` is 0 and `o_done` = 1. Set `ptr = (gid+1) mod N_REQ`, then go to IDLE.
- **Grant lock:**
  - Deassertion of `i_req[gid]` during XFER is ignored; the grant ends only on `last` or abort.
  - `i_valid` from non-granted requesters is ignored.
- **Single-byte message:** `i_last` on the first byte is legal.
- **Throughput limit:** at most one byte per 2 cycles. The `~o_valid_tx` gate covers the one-cycle lag of the UART full flag, so the TX FIFO is never overrun.
- **Reset:**
  - All outputs go to 0 and `ptr` goes to 0.
  - A byte already registered but not yet strobed is dropped.
  - Reset asserted mid-message ends the message; the interrupted requester must restart it.
- **Pointer width:** `ptr` and `gid` are `$clog2(N_REQ)` bits; the wrap is explicit for non-power-of-2 `N_REQ`.

## Timing
- `i_req` high at edge t (in IDLE) → `o_grant`/`o_busy` high from cycle t+1. `o_ready` may be high in cycle t+1.
- Byte handshake at cycle k → `o_valid_tx` = 1 during cycle k+1 only, with `o_tx_sys_data` valid in the same cycle.
- Last-byte handshake at k → the DONE state, `o_done`, the last `o_valid_tx`, and grant drop all occur at k+1 → IDLE at k+2 → next grant at k+3 at the earliest.
- `i_tx_full` high → `o_ready` is 0 in the same cycle (combinational).

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - In XFER, a counter of width `$clog2(TIMEOUT_CYC+1)` increments each cycle with no handshake while `i_tx_full` = 0.
  - The counter clears on every handshake and on entering XFER. It holds while `i_tx_full` = 1.
  - When the counter reaches `TIMEOUT_CYC-1`, pulse `o_abort` with `o_abort_id` = `gid` and go to DONE; `ptr` advances as normal.
- Not defined: no counter, `o_abort` and `o_abort_id` are tied to 0, and the grant is held indefinitely.

## Structure
- `uart_pkg` holds:
  - the `uart_arb_state_t` enum (IDLE/XFER/DONE);
  - `UART_DATA_W` = 8.
- Sub-module `uart_rr_pick`: combinational round-robin picker. Inputs are `req[N_REQ]` and `ptr`; outputs are a one-hot grant and an index.
- The top module holds the FSM, data register, and timeout counter.

## Test plan
- Single requester 1 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on 0xA3) with `i_tx_full` = 0 → three single-cycle `o_valid_tx` strobes at least 2 cycles apart, data in order; `o_done` pulses once; `o_grant` returns to 0.
- Requesters 0 and 2 both hold `i_req` from reset, each sending 2-byte messages, repeated → grant order 0, 2, 0, 2; no byte interleaving within a message.
- `i_tx_full` forced high for 20 cycles mid-message → `o_ready` is 0 throughout and no `o_valid_tx` occurs; transfer resumes with no byte lost or duplicated.
- `rst` asserted for one cycle after byte 2 of a 4-byte message → all outputs 0 the next cycle and `ptr` = 0; the message is re-granted from byte 1 afterwards.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYC` = 16: requester 3 granted but never asserts `i_valid` → `o_abort` = 1 with `o_abort_id` = 3 after 16 cycles, then `o_done`; the grant passes to requester 0 if it is pending.
- Single-byte message 0x55 with `i_last` on the first byte → exactly one strobe carrying 0x55, followed by `o_done`.
